// File: rtl/hfosc_ctrl.sv
// HFOSC power sequencer: arbitrates HF-clock requests and walks the oscillator
// through power-up, enable settle and run, holding it briefly before power-down.
module hfosc_ctrl #(
  parameter int N_REQ       = 2,
  parameter int PU_WAIT     = 3,
  parameter int EN_WAIT     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  input  logic             force_on,
  output logic             CLKHFPU,
  output logic             CLKHFEN,
  output logic             ready,
  output logic [N_REQ-1:0] ack,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    POWERUP = 3'd1,
    STARTUP = 3'd2,
    RUN     = 3'd3,
    HOLD    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  // Waits below one cycle collapse to one; the counter reloads with wait-1.
  localparam int PU_W   = (PU_WAIT < 1) ? 1 : PU_WAIT;
  localparam int EN_W   = (EN_WAIT < 1) ? 1 : EN_WAIT;
  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;

  localparam logic [CW-1:0] PU_LD   = CW'(PU_W - 1);
  localparam logic [CW-1:0] EN_LD   = CW'(EN_W - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_W - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          any_req;
  logic          pu_nxt, en_nxt, rdy_nxt;

  assign any_req = (|req) | force_on;
  assign state_o = state;

  // Request checks always win over counter expiry in every waiting state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      OFF: begin
        if (any_req) begin
          state_nxt = POWERUP;
          cnt_nxt   = PU_LD;
        end
      end
      POWERUP: begin
        if (!any_req) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = STARTUP;
          cnt_nxt   = EN_LD;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      STARTUP: begin
        if (!any_req) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      RUN: begin
        if (!any_req) begin
          if (HOLD_CYCLES == 0) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (any_req) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      DRAIN: begin
        // PU is still high here, so a late request skips the power-up settle.
        if (any_req) begin
          state_nxt = STARTUP;
          cnt_nxt   = EN_LD;
        end else begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    pu_nxt  = 1'b0;
    en_nxt  = 1'b0;
    rdy_nxt = 1'b0;
    case (state_nxt)
      POWERUP: pu_nxt = 1'b1;
      STARTUP: begin
        pu_nxt = 1'b1;
        en_nxt = 1'b1;
      end
      RUN, HOLD: begin
        pu_nxt  = 1'b1;
        en_nxt  = 1'b1;
        rdy_nxt = 1'b1;
      end
      DRAIN:   pu_nxt = 1'b1;
      default: pu_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= OFF;
      cnt     <= '0;
      CLKHFPU <= 1'b0;
      CLKHFEN <= 1'b0;
      ready   <= 1'b0;
      ack     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      CLKHFPU <= pu_nxt;
      CLKHFEN <= en_nxt;
      ready   <= rdy_nxt;
      ack     <= {N_REQ{rdy_nxt}} & req;
    end
  end

`ifndef SYNTHESIS
  a_en_needs_pu: assert property (@(posedge clk) disable iff (!resetn)
    CLKHFEN |-> CLKHFPU);
  a_no_joint_fall: assert property (@(posedge clk) disable iff (!resetn)
    $fell(CLKHFPU) |-> !$fell(CLKHFEN));
  a_ack_needs_ready: assert property (@(posedge clk) disable iff (!resetn)
    (|ack) |-> ready);
`endif

endmodule

// File: tb/tb_hfosc_ctrl.sv
// Scoreboard bench for hfosc_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_hfosc_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic       force_on;
  logic       CLKHFPU, CLKHFEN, ready;
  logic [1:0] ack;
  logic [2:0] state_o;

  localparam logic [2:0] S_OFF = 3'd0, S_PU = 3'd1, S_SU = 3'd2,
                         S_RUN = 3'd3, S_HOLD = 3'd4, S_DRAIN = 3'd5;

  hfosc_ctrl #(.N_REQ(2), .PU_WAIT(3), .EN_WAIT(2), .HOLD_CYCLES(4), .CW(8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .force_on(force_on),
    .CLKHFPU(CLKHFPU), .CLKHFEN(CLKHFEN), .ready(ready), .ack(ack),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       pu, en, rdy;
    logic [1:0] ack;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // pu/en/ready per state, straight from the state table
  function automatic logic [2:0] dec(input logic [2:0] st);
    case (st)
      S_PU, S_DRAIN: return 3'b100;
      S_SU:          return 3'b110;
      S_RUN, S_HOLD: return 3'b111;
      default:       return 3'b000;
    endcase
  endfunction

  // Called at posedge+1: drive inputs, expect outputs after the coming edge.
  task automatic step(input logic [1:0] r, input logic f, input logic [2:0] st,
                      input logic [1:0] a, input string nm);
    exp_t x;
    logic [2:0] o;
    req      = r;
    force_on = f;
    o        = dec(st);
    x.cyc = cyc + 1;
    x.st  = st;
    x.pu  = o[2];
    x.en  = o[1];
    x.rdy = o[0];
    x.ack = a;
    x.nm  = nm;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk({e.nm, ".state"}, {5'd0, state_o}, {5'd0, e.st});
      chk({e.nm, ".pu"},    {7'd0, CLKHFPU}, {7'd0, e.pu});
      chk({e.nm, ".en"},    {7'd0, CLKHFEN}, {7'd0, e.en});
      chk({e.nm, ".ready"}, {7'd0, ready},   {7'd0, e.rdy});
      chk({e.nm, ".ack"},   {6'd0, ack},     {6'd0, e.ack});
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ".state"}, {5'd0, state_o}, 8'd0);
    chk({nm, ".pu"},    {7'd0, CLKHFPU}, 8'd0);
    chk({nm, ".en"},    {7'd0, CLKHFEN}, 8'd0);
    chk({nm, ".ready"}, {7'd0, ready},   8'd0);
    chk({nm, ".ack"},   {6'd0, ack},     8'd0);
  endtask

  task automatic cold_start(input string nm);
    step(2'b01, 1'b0, S_PU,  2'b00, {nm, "_k"});
    step(2'b01, 1'b0, S_PU,  2'b00, {nm, "_k1"});
    step(2'b01, 1'b0, S_PU,  2'b00, {nm, "_k2"});
    step(2'b01, 1'b0, S_SU,  2'b00, {nm, "_k3"});
    step(2'b01, 1'b0, S_SU,  2'b00, {nm, "_k4"});
    step(2'b01, 1'b0, S_RUN, 2'b01, {nm, "_k5"});
  endtask

  initial begin
    resetn   = 1'b0;
    req      = 2'b00;
    force_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    step(2'b00, 1'b0, S_OFF, 2'b00, "idle");

    // cold start, then second requester joins in RUN
    cold_start("cold");
    step(2'b11, 1'b0, S_RUN, 2'b11, "join");

    // idle power-down through the full hold
    step(2'b00, 1'b0, S_HOLD,  2'b00, "pd_m");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "pd_m1");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "pd_m2");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "pd_m3");
    step(2'b00, 1'b0, S_DRAIN, 2'b00, "pd_m4");
    step(2'b00, 1'b0, S_OFF,   2'b00, "pd_m5");

    // force_on alone: full bring-up, never acked
    step(2'b00, 1'b1, S_PU,  2'b00, "frc0");
    step(2'b00, 1'b1, S_PU,  2'b00, "frc1");
    step(2'b00, 1'b1, S_PU,  2'b00, "frc2");
    step(2'b00, 1'b1, S_SU,  2'b00, "frc3");
    step(2'b00, 1'b1, S_SU,  2'b00, "frc4");
    step(2'b00, 1'b1, S_RUN, 2'b00, "frc5");

    // re-request two cycles into HOLD
    step(2'b00, 1'b0, S_HOLD, 2'b00, "rh0");
    step(2'b00, 1'b0, S_HOLD, 2'b00, "rh1");
    step(2'b10, 1'b0, S_RUN,  2'b10, "rh_req");
    step(2'b10, 1'b0, S_RUN,  2'b10, "rh_run");

    // request on the very cycle the hold counter expires
    step(2'b00, 1'b0, S_HOLD, 2'b00, "hx0");
    step(2'b00, 1'b0, S_HOLD, 2'b00, "hx1");
    step(2'b00, 1'b0, S_HOLD, 2'b00, "hx2");
    step(2'b00, 1'b0, S_HOLD, 2'b00, "hx3");
    step(2'b01, 1'b0, S_RUN,  2'b01, "hx_req");

    // re-request in DRAIN
    step(2'b00, 1'b0, S_HOLD,  2'b00, "rd0");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "rd1");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "rd2");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "rd3");
    step(2'b00, 1'b0, S_DRAIN, 2'b00, "rd_drain");
    step(2'b01, 1'b0, S_SU,    2'b00, "rd_su0");
    step(2'b01, 1'b0, S_SU,    2'b00, "rd_su1");
    step(2'b01, 1'b0, S_RUN,   2'b01, "rd_run");

    // abort during power-up
    step(2'b00, 1'b0, S_HOLD,  2'b00, "ab_h0");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "ab_h1");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "ab_h2");
    step(2'b00, 1'b0, S_HOLD,  2'b00, "ab_h3");
    step(2'b00, 1'b0, S_DRAIN, 2'b00, "ab_dr");
    step(2'b00, 1'b0, S_OFF,   2'b00, "ab_off");
    step(2'b10, 1'b0, S_PU,    2'b00, "ab_pu0");
    step(2'b10, 1'b0, S_PU,    2'b00, "ab_pu1");
    step(2'b00, 1'b0, S_OFF,   2'b00, "ab_drop");
    step(2'b00, 1'b0, S_OFF,   2'b00, "ab_stay");

    // async reset mid-cycle while running
    cold_start("pre_rst");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    resetn = 1'b1;
    cold_start("post_rst");

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", sbq.size()[7:0], 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hfosc_ctrl.md
Name: hfosc_ctrl

Overview:
Power sequencer and request arbiter for the on-chip high-frequency oscillator (HFOSC) in the syscon.
- Runs on the always-on low-frequency clock.
- Collects HF-clock requests from N requesters and drives the oscillator's CLKHFPU/CLKHFEN inputs in the required order: power-up settle, enable settle, run.
- Reports clock-ready and per-requester acks.
- Holds the oscillator on for a programmable idle time after the last request drops, then powers it down in reverse order.

Parameters:
N_REQ, 2, number of requesters (1..8).
PU_WAIT, 3, clk cycles CLKHFPU is high before CLKHFEN rises; values below 1 are treated as 1.
EN_WAIT, 2, clk cycles after CLKHFEN rises before ready; values below 1 are treated as 1.
HOLD_CYCLES, 4, idle clk cycles in HOLD before power-down; 0 means no hold.
CW, 8, width of the internal down-counter; must be wide enough for the largest of the three waits.

Ports:
clk  input  1  always-on low-frequency clock; rising-edge.
resetn  input  1  asynchronous, active-low reset.
req  input  N_REQ  per-requester HF-clock request, level-sensitive, synchronous to clk.
force_on  input  1  treated as an extra request bit; OR'd with req.
CLKHFPU  output  1  oscillator power-up, registered.
CLKHFEN  output  1  oscillator enable, registered.
ready  output  1  HF clock is stable and usable, registered.
ack  output  N_REQ  per-requester grant, registered.
state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Definition: any_req = |req | force_on, sampled on the rising edge of clk.
- Reset (resetn low, asynchronous): state OFF; CLKHFPU=0, CLKHFEN=0, ready=0, ack=0, counter=0. Release is taken on the next clk edge. Reset mid-sequence drops all outputs immediately and does not wait.

State encoding and outputs (pu/en/ready):
- OFF=0: 0/0/0
- POWERUP=1: 1/0/0
- STARTUP=2: 1/1/0
- RUN=3: 1/1/1
- HOLD=4: 1/1/1
- DRAIN=5: 1/0/0
- Outputs are decoded from the next state and registered, so they change on the same edge as the state.

Transitions:
- OFF: any_req -> POWERUP, counter loaded with PU_WAIT-1.
- POWERUP:
  - !any_req -> OFF (abort).
  - Else if counter==0 -> STARTUP, counter loaded with EN_WAIT-1.
  - Else decrement.
  - CLKHFPU is high for exactly PU_WAIT cycles before CLKHFEN rises.
- STARTUP:
  - !any_req -> DRAIN.
  - Else if counter==0 -> RUN.
  - Else decrement.
- RUN: !any_req -> HOLD with counter loaded with HOLD_CYCLES-1, or directly -> DRAIN if HOLD_CYCLES==0.
- HOLD:
  - any_req -> RUN; counter is discarded and ready never drops.
  - Else if counter==0 -> DRAIN.
  - Else decrement.
- DRAIN (one cycle, CLKHFEN already low):
  - any_req -> STARTUP with counter EN_WAIT-1; PU stays high, so no re-settle.
  - Else -> OFF.

Ordering guarantees:
- CLKHFEN is never high while CLKHFPU is low.
- CLKHFPU never falls in the same cycle CLKHFEN falls.

ack rules:
- ack[i] <= next_ready & req[i].
- ack is never high while ready is low.
- A requester raising req while in RUN gets ack on the next edge.
- force_on generates no ack.

Simultaneous events:
- Request rise and counter expiry in the same cycle follow the table above; request checks take priority over counter expiry.

Test Plan:
1. Cold start: reset, then req=2'b01 sampled at edge k -> CLKHFPU=1 at k; CLKHFEN=1 at k+3; ready=1, ack=2'b01 at k+5.
2. Idle power-down: from RUN, req drops at edge m -> HOLD at m with ready held at 1; DRAIN at m+4 (CLKHFEN=0, ready=0, CLKHFPU=1); OFF at m+5 (CLKHFPU=0).
3. Re-request in HOLD: req=2'b10 two cycles into HOLD -> RUN on the next edge; ready stays 1 throughout; ack=2'b10 on that edge.
4. Abort in POWERUP: req pulses high for 2 cycles only -> CLKHFPU high for 2 cycles, back to OFF, CLKHFEN never rises.
5. Re-request in DRAIN: req rises in the DRAIN cycle -> STARTUP with CLKHFPU never low; ready=1 two cycles later.
6. Async reset in RUN: resetn falls mid-cycle -> all outputs 0 immediately, before the next clk edge; after release with req held high, the full cold-start sequence of scenario 1 repeats.
